// File: rtl/mem_block_summer.sv
// Block-sum sequencer for the 256x8 data memory: reads COUNT bytes from a base
// address, accumulates a 16-bit sum, then writes it back little-endian to a destination.
module mem_block_summer #(
  parameter bit SIGNED_ELEMS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [7:0]  count,
  input  logic [7:0]  dest_addr,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_store,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum
);

  typedef enum logic [2:0] {IDLE, READ, WR_LO, WR_HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  dest_q, dest_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] ext_rdata;

  assign ext_rdata = SIGNED_ELEMS ? {{8{mem_rdata[7]}}, mem_rdata} : {8'h00, mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= 8'h00;
      cnt_q   <= 8'h00;
      dest_q  <= 8'h00;
      idx_q   <= 8'h00;
      acc_q   <= 16'h0000;
      sum_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = count;
          dest_d  = dest_addr;
          idx_d   = 8'h00;
          acc_d   = 16'h0000;
          state_d = (count != 8'h00) ? READ : WR_LO;
        end
      end
      READ: begin
        acc_d = acc_q + ext_rdata;
        idx_d = idx_q + 8'd1;
        if (idx_q == cnt_q - 8'd1) state_d = WR_LO;
      end
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        state_d = DONE;
        sum_d   = acc_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state, never on start or mem_rdata.
  always_comb begin
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_store = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE:  busy = 1'b0;
      READ:  mem_addr = base_q + idx_q;
      WR_LO: begin
        mem_addr  = dest_q;
        mem_wdata = acc_q[7:0];
        mem_store = 1'b1;
      end
      WR_HI: begin
        mem_addr  = dest_q + 8'd1;
        mem_wdata = acc_q[15:8];
        mem_store = 1'b1;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_mem_block_summer.sv
// Bench for mem_block_summer: signed and unsigned instances share stimulus, each
// with its own 256x8 memory, checked against an arithmetic model of the block sum.
module tb_mem_block_summer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00, count = 8'h00, dest_addr = 8'h00;
  logic [7:0]  a_s, wd_s, rd_s, a_u, wd_u, rd_u;
  logic        st_s, st_u, busy_s, busy_u, done_s, done_u;
  logic [15:0] sum_s, sum_u;

  logic        tb_we = 1'b0;
  logic [7:0]  tb_addr = 8'h00, tb_wd = 8'h00;
  logic [7:0]  mem_s [256];
  logic [7:0]  mem_u [256];
  logic [7:0]  ref_s [256];
  logic [7:0]  ref_u [256];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_block_summer #(.SIGNED_ELEMS(1'b1)) u_s (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .dest_addr(dest_addr), .mem_addr(a_s), .mem_wdata(wd_s), .mem_store(st_s),
    .mem_rdata(rd_s), .busy(busy_s), .done(done_s), .sum(sum_s));

  mem_block_summer #(.SIGNED_ELEMS(1'b0)) u_u (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .dest_addr(dest_addr), .mem_addr(a_u), .mem_wdata(wd_u), .mem_store(st_u),
    .mem_rdata(rd_u), .busy(busy_u), .done(done_u), .sum(sum_u));

  assign rd_s = mem_s[a_s];
  assign rd_u = mem_u[a_u];

  always @(posedge clk) begin
    if (tb_we) begin
      mem_s[tb_addr] <= tb_wd;
      mem_u[tb_addr] <= tb_wd;
    end else begin
      if (st_s) mem_s[a_s] <= wd_s;
      if (st_u) mem_u[a_u] <= wd_u;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wd = d;
    ref_s[a] = d; ref_u[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic int mem_diffs();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_s[i] !== ref_s[i]) n++;
      if (mem_u[i] !== ref_u[i]) n++;
    end
    return n;
  endfunction

  // Model: plain integer sum over the source window (wrapping addresses), taken
  // before any write-back, then truncated to 16 bits.
  task automatic run_job(input string tag, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input bit restart);
    int acc_s, acc_u, dk_s, dk_u, nd_s, nd_u, v;
    logic [7:0]  ad, d1;
    logic [15:0] es, eu;
    acc_s = 0; acc_u = 0;
    for (int i = 0; i < int'(c); i++) begin
      ad = b + i[7:0];
      v = int'(ref_s[ad]);
      acc_s += (v >= 128) ? v - 256 : v;
      acc_u += int'(ref_u[ad]);
    end
    es = acc_s[15:0];
    eu = acc_u[15:0];
    d1 = d + 8'd1;
    @(negedge clk);
    base_addr = b; count = c; dest_addr = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = 8'($urandom); count = 8'($urandom); dest_addr = 8'($urandom);
    dk_s = -1; dk_u = -1; nd_s = 0; nd_u = 0;
    for (int k = 1; k <= int'(c) + 8; k++) begin
      if (k == 1) begin
        chk({tag, " busy_s"}, busy_s, 1);
        chk({tag, " busy_u"}, busy_u, 1);
      end
      if (done_s) begin nd_s++; if (dk_s < 0) dk_s = k; end
      if (done_u) begin nd_u++; if (dk_u < 0) dk_u = k; end
      if (restart && k == 2) begin
        start = 1'b1; base_addr = b + 8'd3; count = 8'd2; dest_addr = d + 8'd7;
      end
      if (restart && k == 3) start = 1'b0;
      @(negedge clk);
    end
    chk({tag, " latency_s"}, dk_s, int'(c) + 3);
    chk({tag, " latency_u"}, dk_u, int'(c) + 3);
    chk({tag, " ndone_s"}, nd_s, 1);
    chk({tag, " ndone_u"}, nd_u, 1);
    ref_s[d] = es[7:0]; ref_s[d1] = es[15:8];
    ref_u[d] = eu[7:0]; ref_u[d1] = eu[15:8];
    chk({tag, " sum_s"}, sum_s, es);
    chk({tag, " sum_u"}, sum_u, eu);
    chk({tag, " mem_s lo"}, mem_s[d], es[7:0]);
    chk({tag, " mem_s hi"}, mem_s[d1], es[15:8]);
    chk({tag, " mem_u lo"}, mem_u[d], eu[7:0]);
    chk({tag, " mem_u hi"}, mem_u[d1], eu[15:8]);
    chk({tag, " mem image"}, mem_diffs(), 0);
  endtask

  initial begin
    logic [7:0] tp [20];
    int nd;
    tp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
           8'd11, 8'd15, 8'd14, 8'd13, 8'd12, 8'd10, 8'hF8, 8'd10, 8'd1, 8'd10};
    for (int i = 0; i < 256; i++) begin
      ref_s[i] = 8'h00; ref_u[i] = 8'h00;
    end
    tb_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tb_addr = i[7:0]; tb_wd = 8'h00;
      @(negedge clk);
    end
    tb_we = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst addr",  {a_s, a_u}, 0);
    chk("rst wdata", {wd_s, wd_u}, 0);
    chk("rst store", {st_s, st_u}, 0);
    chk("rst busy",  {busy_s, busy_u}, 0);
    chk("rst done",  {done_s, done_u}, 0);
    chk("rst sum",   {sum_s, sum_u}, 0);

    for (int i = 0; i < 20; i++) poke(8'd100 + i[7:0], tp[i]);
    run_job("plan20", 8'd100, 8'd20, 8'd200, 1'b0);
    chk("plan20 signed sum", sum_s, 32'h008F);
    chk("plan20 unsigned sum", sum_u, 32'h018F);

    poke(8'd50, 8'hAA); poke(8'd51, 8'h55);
    run_job("count0", 8'd10, 8'd0, 8'd50, 1'b0);
    chk("count0 mem50", mem_s[50], 0);

    poke(8'd254, 8'h7F); poke(8'd255, 8'h7F); poke(8'd0, 8'h7F); poke(8'd1, 8'h7F);
    run_job("wrap", 8'd254, 8'd4, 8'd255, 1'b0);
    chk("wrap mem0", mem_s[0], 32'h01);

    run_job("restart", 8'd100, 8'd20, 8'd200, 1'b1);

    // Abort in the middle of READ.
    poke(8'd210, 8'h11); poke(8'd211, 8'h22);
    @(negedge clk);
    base_addr = 8'd100; count = 8'd20; dest_addr = 8'd210; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy",  {busy_s, busy_u}, 0);
    chk("abort store", {st_s, st_u}, 0);
    chk("abort sum",   {sum_s, sum_u}, 0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (done_s || done_u || st_s || st_u) nd++;
      @(negedge clk);
    end
    chk("abort no done/store", nd, 0);
    chk("abort mem image", mem_diffs(), 0);
    run_job("post-abort", 8'd100, 8'd20, 8'd210, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 12; j++) poke(8'($urandom), 8'($urandom));
      run_job($sformatf("rand%0d", r), 8'($urandom), 8'($urandom_range(0, 40)),
              8'($urandom), r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
